// File: rtl/graphics_pkg.sv
// Shared types and constants for the block-draw control path.
// Holds the state encoding, pixel geometry and the Moore output decode.
package graphics_pkg;

  localparam int unsigned PIXELS_PER_BLOCK = 64;
  localparam int unsigned PIX_W            = 6;
  localparam logic [2:0]  WHITE            = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_FLASH,
    S_FLASH_DRAW,
    S_HOLD,
    S_RESTORE,
    S_RESTORE_DRAW,
    S_DONE
  } state_t;

  typedef struct packed {
    logic ready;
    logic busy;
    logic done;
    logic load;
    logic enable;
    logic flash;
    logic ld_previous;
    logic plot;
  } ctrl_t;

  // Strobe pattern for each state; the three datapath reload strobes are mutually exclusive.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c       = '0;
    c.ready = (s == S_IDLE);
    c.busy  = (s != S_IDLE);
    case (s)
      S_LOAD: begin
        c.load   = 1'b1;
        c.enable = 1'b1;
      end
      S_DRAW, S_FLASH_DRAW, S_RESTORE_DRAW: begin
        c.enable = 1'b1;
        c.plot   = 1'b1;
      end
      S_FLASH:   c.flash       = 1'b1;
      S_RESTORE: c.ld_previous = 1'b1;
      S_DONE:    c.done        = 1'b1;
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/graphics_control_hold_timer.sv
// Down-counter timing how long the white block stays on screen.
// 'start' loads CYCLES-1; 'expired' is high once the count reaches zero.
module hold_timer #(
  parameter int unsigned CYCLES = 25_000_000,
  parameter int unsigned W      = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  output logic expired
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = W'(CYCLES - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Expired is registered alongside the count so it always mirrors cnt_q == 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      expired <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      expired <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/graphics_control.sv
// Sequences datapath strobes and VGA plot so each request paints one 8x8 block,
// optionally flashing it white for HOLD_CYCLES before restoring the original colour.
module graphics_control
  import graphics_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 25_000_000,
  parameter int unsigned HOLD_W      = 25
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic flash_req,
  output logic ready,
  output logic busy,
  output logic done,
  output logic load,
  output logic enable,
  output logic flash,
  output logic ld_previous,
  output logic plot
);

  state_t           state_q, state_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             flash_q, flash_d;
  logic             hold_start;
  logic             hold_expired;
  logic             pix_last;
  ctrl_t            ctrl_q;

  assign pix_last = (pix_q == PIX_W'(PIXELS_PER_BLOCK - 1));

  hold_timer #(
    .CYCLES(HOLD_CYCLES),
    .W     (HOLD_W)
  ) u_hold_timer (
    .clock  (clock),
    .reset  (reset),
    .start  (hold_start),
    .expired(hold_expired)
  );

  // Next state; pix only advances inside draw phases and is zero on entry to each.
  always_comb begin
    state_d    = state_q;
    flash_d    = flash_q;
    pix_d      = '0;
    hold_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          flash_d = flash_req;
          state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_DRAW;
      S_DRAW: begin
        pix_d = pix_q + PIX_W'(1);
        if (pix_last) state_d = flash_q ? S_FLASH : S_DONE;
      end
      S_FLASH: state_d = S_FLASH_DRAW;
      S_FLASH_DRAW: begin
        pix_d = pix_q + PIX_W'(1);
        if (pix_last) begin
          state_d    = S_HOLD;
          hold_start = 1'b1;
        end
      end
      S_HOLD: begin
        if (hold_expired) state_d = S_RESTORE;
      end
      S_RESTORE: state_d = S_RESTORE_DRAW;
      S_RESTORE_DRAW: begin
        pix_d = pix_q + PIX_W'(1);
        if (pix_last) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so they line up with the state they decode.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      flash_q <= 1'b0;
      ctrl_q  <= decode(S_IDLE);
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      flash_q <= flash_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign ready       = ctrl_q.ready;
  assign busy        = ctrl_q.busy;
  assign done        = ctrl_q.done;
  assign load        = ctrl_q.load;
  assign enable      = ctrl_q.enable;
  assign flash       = ctrl_q.flash;
  assign ld_previous = ctrl_q.ld_previous;
  assign plot        = ctrl_q.plot;

endmodule

// File: tb/tb_graphics_control.sv
// Scoreboard bench for graphics_control with a small datapath colour/counter model.
module tb_graphics_control;
  import graphics_pkg::*;

  localparam int unsigned HOLD = 4;

  logic clock, reset, req, flash_req;
  logic ready, busy, done, load, enable, flash, ld_previous, plot;
  logic [2:0] col_in;

  graphics_control #(.HOLD_CYCLES(HOLD), .HOLD_W(3)) dut (
    .clock(clock), .reset(reset), .req(req), .flash_req(flash_req),
    .ready(ready), .busy(busy), .done(done), .load(load), .enable(enable),
    .flash(flash), .ld_previous(ld_previous), .plot(plot)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int load_at, first_plot, last_plot, flash_at, ldp_at, done_at;
    int plot_n, white_n, orig_n, load_n;
  } exp_t;

  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected timeline relative to the cycle in which req is sampled.
  function automatic exp_t make_exp(input bit fl);
    exp_t e;
    e.load_at    = 1;
    e.load_n     = 1;
    e.first_plot = 2;
    if (fl) begin
      e.flash_at = 2 + 64;
      e.ldp_at   = e.flash_at + 1 + 64 + int'(HOLD);
      e.done_at  = e.ldp_at + 1 + 64;
      e.plot_n   = 192;
      e.white_n  = 64;
      e.orig_n   = 128;
    end else begin
      e.flash_at = -1;
      e.ldp_at   = -1;
      e.done_at  = 66;
      e.plot_n   = 64;
      e.white_n  = 0;
      e.orig_n   = 64;
    end
    e.last_plot = e.done_at - 1;
    return e;
  endfunction

  // Datapath model: counter cleared by load, advanced by enable; colour forced/restored.
  logic [2:0] m_saved, m_cur;
  logic [5:0] m_cnt;
  always @(posedge clock) begin
    if (load) begin
      m_saved <= col_in;
      m_cur   <= col_in;
      m_cnt   <= '0;
    end else begin
      if (flash)       m_cur <= WHITE;
      if (ld_previous) m_cur <= m_saved;
      if (enable)      m_cnt <= m_cnt + 6'd1;
    end
  end

  int cyc = 0, t0 = 0, txn = 0, accepts = 0, done_total = 0, stray_done = 0;
  int viol_excl = 0, viol_plot = 0, viol_rdy = 0;
  bit active = 1'b0;
  int load_n, load_at, first_plot, last_plot, flash_at, ldp_at, plot_n, white_n, orig_n;
  logic [2:0]  acc_col;
  logic [63:0] mask;

  always @(negedge clock) begin
    int rel;
    exp_t e;
    cyc++;
    if (int'(load) + int'(flash) + int'(ld_previous) > 1) viol_excl++;
    if (plot && !enable) viol_plot++;
    if (ready == busy) viol_rdy++;
    if (reset) begin
      active = 1'b0;
    end else begin
      if (active) begin
        rel = cyc - t0;
        if (load)        begin load_n++; if (load_at < 0) load_at = rel; mask = '0; end
        if (flash)       begin if (flash_at < 0) flash_at = rel; mask = '0; end
        if (ld_previous) begin if (ldp_at < 0) ldp_at = rel; mask = '0; end
        if (plot) begin
          plot_n++;
          if (first_plot < 0) first_plot = rel;
          last_plot   = rel;
          mask[m_cnt] = 1'b1;
          if (m_cur == WHITE)   white_n++;
          if (m_cur == acc_col) orig_n++;
        end
        if (done) begin
          done_total++;
          active = 1'b0;
          if (exp_q.size() == 0) begin
            check($sformatf("t%0d_sb_underflow", txn), 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("t%0d_done_at", txn),    64'(rel),        64'(e.done_at));
            check($sformatf("t%0d_load_at", txn),    64'(load_at),    64'(e.load_at));
            check($sformatf("t%0d_load_n", txn),     64'(load_n),     64'(e.load_n));
            check($sformatf("t%0d_first_plot", txn), 64'(first_plot), 64'(e.first_plot));
            check($sformatf("t%0d_last_plot", txn),  64'(last_plot),  64'(e.last_plot));
            check($sformatf("t%0d_flash_at", txn),   64'(flash_at),   64'(e.flash_at));
            check($sformatf("t%0d_ldprev_at", txn),  64'(ldp_at),     64'(e.ldp_at));
            check($sformatf("t%0d_plot_n", txn),     64'(plot_n),     64'(e.plot_n));
            check($sformatf("t%0d_white_n", txn),    64'(white_n),    64'(e.white_n));
            check($sformatf("t%0d_orig_n", txn),     64'(orig_n),     64'(e.orig_n));
            check($sformatf("t%0d_pix_cover", txn),  mask,            {64{1'b1}});
          end
        end
      end else if (done) begin
        stray_done++;
      end
      if (ready && req) begin
        active  = 1'b1;
        t0      = cyc;
        accepts++;
        txn     = accepts;
        acc_col = col_in;
        mask    = '0;
        load_n  = 0;  load_at = -1; first_plot = -1; last_plot = -1;
        flash_at = -1; ldp_at = -1; plot_n = 0; white_n = 0; orig_n = 0;
      end
    end
  end

  // Call just after a rising edge; req is high for exactly one cycle.
  task automatic issue(input bit fl, input logic [2:0] col);
    #2;
    col_in    = col;
    flash_req = fl;
    req       = 1'b1;
    exp_q.push_back(make_exp(fl));
    @(posedge clock);
    #2;
    req       = 1'b0;
    flash_req = !fl;
  endtask

  task automatic wait_done(input int budget);
    int n  = 0;
    int d0 = done_total;
    while (done_total == d0 && n < budget) begin
      @(posedge clock);
      n++;
    end
    check("done_within_budget", 64'(done_total != d0), 64'd1);
  endtask

  initial begin
    int t_a, snap;
    reset = 1'b1; req = 1'b0; flash_req = 1'b0; col_in = 3'd0;
    repeat (3) @(posedge clock);
    #1 check("reset_outputs", {ready, busy, done, load, enable, flash, ld_previous, plot}, 8'b1000_0000);
    @(posedge clock); #2 reset = 1'b0;

    repeat (10) @(posedge clock);
    #1 check("idle_ready", 64'(ready), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_strobes", {done, load, enable, flash, ld_previous, plot}, 6'b0);

    @(posedge clock); issue(1'b0, 3'd5); wait_done(100);
    @(posedge clock); issue(1'b1, 3'd2); wait_done(300);

    // Extra req pulses while busy must be ignored.
    @(posedge clock); issue(1'b0, 3'd3);
    repeat (10) @(posedge clock);
    #2 req = 1'b1; flash_req = 1'b1;
    @(posedge clock); #2 req = 1'b0; flash_req = 1'b0;
    repeat (20) @(posedge clock);
    #2 req = 1'b1;
    @(posedge clock); #2 req = 1'b0;
    wait_done(100);

    // Back-to-back: second req raised in the cycle right after done.
    @(posedge clock); issue(1'b0, 3'd1); t_a = t0;
    wait_done(100);
    issue(1'b0, 3'd6);
    check("b2b_spacing", 64'(t0 - t_a), 64'd67);
    wait_done(100);

    // Reset at DRAW cycle 30 aborts the block without done.
    @(posedge clock); issue(1'b0, 3'd4);
    repeat (31) @(posedge clock);
    #2 reset = 1'b1;
    #1 check("rst_plot", 64'(plot), 64'd0);
    check("rst_ready_busy", {ready, busy, done}, 3'b100);
    void'(exp_q.pop_front());
    snap = done_total;
    repeat (3) @(posedge clock);
    #2 reset = 1'b0;
    repeat (80) @(posedge clock);
    check("rst_no_done", 64'(done_total), 64'(snap));
    check("rst_idle", {ready, busy}, 2'b10);
    @(posedge clock); issue(1'b0, 3'd6); wait_done(100);
    @(posedge clock); issue(1'b1, 3'd1); wait_done(300);

    repeat (5) @(posedge clock);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
    check("stray_done", 64'(stray_done), 64'd0);
    check("one_done_per_accept", 64'(done_total), 64'(accepts - 1));
    check("strobe_exclusive", 64'(viol_excl), 64'd0);
    check("plot_implies_enable", 64'(viol_plot), 64'd0);
    check("ready_not_busy", 64'(viol_rdy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
